// File: rtl/video_line_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_line_fetcher_if
//  Purpose  : Framebuffer read bus between the line fetcher and memory.
//             Single outstanding request; data is valid in the ack cycle.
//  Revision : 1.0  initial release
// ============================================================================
interface video_line_fetcher_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [23:0]           mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface
`default_nettype wire

// File: rtl/video_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : video_line_fetcher
//  Purpose  : Ping-pong line buffer. Each line start swaps the displayed bank
//             and prefetches the next visible line into the idle bank; the
//             displayed bank is read by x_index with one cycle of latency.
//  Revision : 1.0  initial release
// ============================================================================
module video_line_fetcher #(
  parameter int                  LINE_WIDTH    = 400,
  parameter int                  LINE_COUNT    = 360,
  parameter int                  ADDR_WIDTH    = 18,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                  X_INDEX_WIDTH = $clog2(LINE_WIDTH),
  parameter int                  Y_INDEX_WIDTH = $clog2(LINE_COUNT)
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  input  wire logic                     line_start,
  input  wire logic [Y_INDEX_WIDTH-1:0] y_index,
  input  wire logic                     y_index_valid,
  input  wire logic [X_INDEX_WIDTH-1:0] x_index,
  input  wire logic                     x_index_valid,
  output logic      [23:0]              rgb_out,
  video_line_fetcher_if.master          mem,
  input  wire logic                     underrun_clear,
  output logic                          busy,
  output logic                          underrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_line_start_d;
  logic                     r_display_bank;
  logic [X_INDEX_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_underrun;
  logic                     w_mem_req;
  logic                     w_busy;
  logic                     w_line_event;
  logic                     w_ack;
  logic                     w_last;
  logic [Y_INDEX_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0]    w_fill_base;

  // Bank storage is deliberately not reset so it maps onto plain RAM.
  logic [23:0] r_bank0 [LINE_WIDTH];
  logic [23:0] r_bank1 [LINE_WIDTH];

  // A held line_start yields a single event on its rising edge only.
  assign w_line_event = line_start & ~r_line_start_d;
  // Acks outside FILL belong to no request and are dropped.
  assign w_ack        = (r_state == ST_FILL) & mem.mem_ack;
  assign w_last       = (r_col == X_INDEX_WIDTH'(LINE_WIDTH - 1));

  // During vertical blank (or on the last visible line) line 0 is prefetched.
  assign w_target = (!y_index_valid || (y_index == Y_INDEX_WIDTH'(LINE_COUNT - 1)))
                    ? '0 : y_index + 1'b1;
  assign w_fill_base = BASE_ADDR + ADDR_WIDTH'(w_target) * ADDR_WIDTH'(LINE_WIDTH);

  assign mem.mem_req  = w_mem_req;
  assign mem.mem_addr = r_addr;
  assign busy         = w_busy;
  assign underrun     = r_underrun;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and request outputs; a line event restarts the fill from any state.
  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_IDLE;
      ST_FILL: begin
        w_mem_req = 1'b1;
        w_busy    = 1'b1;
        if (w_ack && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_line_event) begin
      w_state_next = ST_FILL;
    end
  end

  // Fill bookkeeping: bank swap, column counter and address, which only moves after an ack or event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_start_d <= 1'b0;
      r_display_bank <= 1'b0;
      r_col          <= '0;
      r_addr         <= '0;
    end else begin
      r_line_start_d <= line_start;
      if (w_line_event) begin
        r_display_bank <= ~r_display_bank;
        r_col          <= '0;
        r_addr         <= w_fill_base;
      end else if (w_ack) begin
        r_col  <= r_col + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Sticky underrun: an event that lands mid-fill sets it, and a set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 1'b0;
    end else if (w_line_event && (r_state == ST_FILL)) begin
      r_underrun <= 1'b1;
    end else if (underrun_clear) begin
      r_underrun <= 1'b0;
    end
  end

  // Fill write port: always the bank not on display, so an ack coincident with
  // an event still lands in the bank that is about to be shown.
  always_ff @(posedge clk) begin
    if (w_ack) begin
      if (r_display_bank) begin
        r_bank0[r_col] <= mem.mem_data;
      end else begin
        r_bank1[r_col] <= mem.mem_data;
      end
    end
  end

  // Registered display read, zero outside the active window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out <= '0;
    end else if (x_index_valid) begin
      rgb_out <= r_display_bank ? r_bank1[x_index] : r_bank0[x_index];
    end else begin
      rgb_out <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_line_fetcher
//  Purpose  : Scoreboard bench for video_line_fetcher with a 4-pixel line,
//             8 lines and base address 0x100. Memory returns 0xA8 in the top
//             bits over the word address, so pixel data identifies its source.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_line_fetcher;
  localparam int          LW   = 4;
  localparam int          LC   = 8;
  localparam int          AW   = 18;
  localparam logic [17:0] BASE = 18'h100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       line_start;
  logic [2:0] y_index;
  logic       y_index_valid;
  logic [1:0] x_index;
  logic       x_index_valid;
  logic [23:0] rgb_out;
  logic       mem_ack;
  logic       underrun_clear;
  logic       busy;
  logic       underrun;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt  = 0;

  logic [17:0] exp_addr[$];
  logic [23:0] exp_pix[$];
  logic        rd_issue   = 1'b0;
  logic        rd_seen    = 1'b0;
  logic        chk_stable = 1'b0;
  logic        prev_req   = 1'b0;
  logic        prev_ack   = 1'b0;
  logic [17:0] prev_addr  = '0;

  video_line_fetcher_if #(.ADDR_WIDTH(AW)) mif ();
  assign mif.mem_ack  = mem_ack;
  assign mif.mem_data = {6'h2A, mif.mem_addr};

  video_line_fetcher #(
    .LINE_WIDTH(LW), .LINE_COUNT(LC), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start),
    .y_index(y_index), .y_index_valid(y_index_valid),
    .x_index(x_index), .x_index_valid(x_index_valid),
    .rgb_out(rgb_out), .mem(mif), .underrun_clear(underrun_clear),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted request and every read result is scored against the queues.
  always @(negedge clk) begin
    if (reset_n && mif.mem_req && mem_ack) begin
      ack_cnt++;
      if (exp_addr.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got addr 0x%0h expected no request", mif.mem_addr);
      end else begin
        check("mem_addr", 32'(mif.mem_addr), 32'(exp_addr.pop_front()));
      end
    end
    if (chk_stable && reset_n && prev_req && !prev_ack && mif.mem_req)
      check("addr_stable", 32'(mif.mem_addr), 32'(prev_addr));
    prev_req  = reset_n & mif.mem_req;
    prev_ack  = mem_ack;
    prev_addr = mif.mem_addr;
    if (rd_seen) begin
      if (exp_pix.size() == 0) begin
        n_checks++;
        $display("FAIL pix_queue: got read with empty queue, rgb 0x%0h", rgb_out);
      end else begin
        check("rgb_out", 32'(rgb_out), 32'(exp_pix.pop_front()));
      end
    end
    rd_seen = rd_issue;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [17:0] base);
    for (int k = 0; k < LW; k++) exp_addr.push_back(base + 18'(k));
  endtask

  task automatic fill_cycles(input int hold, input int ncyc, input bit rnd, output int bcnt);
    bcnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      line_start = (i < hold);
      if (rnd) mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) bcnt++;
      step();
    end
    line_start = 1'b0;
  endtask

  task automatic read_px(input logic [1:0] xi, input bit v, input logic [23:0] e);
    x_index       = xi;
    x_index_valid = v;
    rd_issue      = 1'b1;
    exp_pix.push_back(e);
    step();
  endtask

  task automatic read_line(input logic [17:0] base);
    for (int k = 0; k < LW; k++) read_px(2'(k), 1'b1, {6'h2A, base + 18'(k)});
    read_px(2'd1, 1'b0, 24'h0);
    rd_issue      = 1'b0;
    x_index_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bc;
    int ack_base;
    reset_n = 1'b1; line_start = 0; y_index = 0; y_index_valid = 0;
    x_index = 0; x_index_valid = 0; mem_ack = 0; underrun_clear = 0;
    #2 reset_n = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check("rst_rgb", 32'(rgb_out), 0);
    check("rst_req", 32'(mif.mem_req), 0);
    check("rst_addr", 32'(mif.mem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(underrun), 0);
    step();
    reset_n = 1'b1;
    step();

    // Single fill: line 2 -> target 3 -> 0x10C..0x10F with ack held high
    y_index_valid = 1; y_index = 3'd2; mem_ack = 1;
    push_line(18'h10C);
    fill_cycles(1, 10, 0, bc);
    check("t1_busy_cycles", 32'(bc), 4);
    @(negedge clk);
    check("t1_req_low", 32'(mif.mem_req), 0);
    check("t1_queue", 32'(exp_addr.size()), 0);
    step();

    // Bank swap then readback of the words just fetched; new fill left pending
    mem_ack = 0;
    fill_cycles(1, 3, 0, bc);
    @(negedge clk);
    check("t2_pending_addr", 32'(mif.mem_addr), 32'h10C);
    check("t2_underrun", 32'(underrun), 0);
    step();
    read_line(18'h10C);

    // Underrun after 2 of 4 acks; new target line 6 -> 0x118
    push_line(18'h10C);
    void'(exp_addr.pop_back()); void'(exp_addr.pop_back());
    mem_ack = 1; step(); step(); mem_ack = 0;
    y_index = 3'd5;
    fill_cycles(1, 2, 0, bc);
    @(negedge clk);
    check("t3_underrun_set", 32'(underrun), 1);
    check("t3_restart_addr", 32'(mif.mem_addr), 32'h118);
    step();
    push_line(18'h118);
    mem_ack = 1;
    fill_cycles(0, 8, 0, bc);
    check("t3_refill_busy", 32'(bc), 4);
    mem_ack = 0;
    underrun_clear = 1; step(); underrun_clear = 0;
    @(negedge clk);
    check("t3_cleared", 32'(underrun), 0);
    step();
    fill_cycles(1, 2, 0, bc);
    line_start = 1; underrun_clear = 1; step();
    line_start = 0; underrun_clear = 0;
    @(negedge clk);
    check("t3_set_wins", 32'(underrun), 1);
    step();
    underrun_clear = 1; step(); underrun_clear = 0;

    // Wrap on the last visible line, then vertical blank: both target line 0
    y_index = 3'd7;
    fill_cycles(1, 2, 0, bc);
    @(negedge clk);
    check("t4_wrap_addr", 32'(mif.mem_addr), 32'h100);
    step();
    push_line(18'h100);
    mem_ack = 1;
    fill_cycles(0, 8, 0, bc);
    check("t4_wrap_busy", 32'(bc), 4);
    y_index_valid = 0; y_index = 3'd3;
    push_line(18'h100);
    fill_cycles(1, 10, 0, bc);
    check("t4_blank_busy", 32'(bc), 4);
    mem_ack = 0;
    underrun_clear = 1; step(); underrun_clear = 0;

    // Held line_start with random backpressure: one fill of line 1 only
    y_index_valid = 1; y_index = 3'd0;
    push_line(18'h104);
    chk_stable = 1;
    ack_base   = ack_cnt;
    fill_cycles(3, 80, 1, bc);
    chk_stable = 0;
    mem_ack    = 0;
    @(negedge clk);
    check("t5_ack_count", 32'(ack_cnt - ack_base), 4);
    check("t5_done", 32'(busy), 0);
    check("t5_no_underrun", 32'(underrun), 0);
    step();

    // Reset in the middle of a fill with underrun pending and a read active
    fill_cycles(1, 2, 0, bc);
    fill_cycles(1, 2, 0, bc);
    x_index = 2'd0; x_index_valid = 1;
    step();
    reset_n = 1'b0;
    #1;
    check("t6_req", 32'(mif.mem_req), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_underrun", 32'(underrun), 0);
    check("t6_rgb", 32'(rgb_out), 0);
    mem_ack = 1;
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    @(negedge clk);
    check("t6_idle_req", 32'(mif.mem_req), 0);
    check("t6_idle_addr", 32'(mif.mem_addr), 0);
    step();
    x_index_valid = 0; y_index = 3'd1;
    push_line(18'h108);
    fill_cycles(1, 10, 0, bc);
    check("t6_clean_busy", 32'(bc), 4);
    mem_ack = 0;
    fill_cycles(1, 3, 0, bc);
    read_line(18'h108);

    check("final_addr_queue", 32'(exp_addr.size()), 0);
    check("final_pix_queue", 32'(exp_pix.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
